// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative DES decryption engine, R Feistel rounds per clock
// Subkeys are produced K16 first by right-rotating the PC-1 halves, so no key storage is needed.
module des_decrypt_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [63:0] key_in,
   input  logic [63:0] data_in,
   output logic [63:0] data_out,
   output logic        busy,
   output logic        done
);

   generate
      if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
            ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
         $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] ROUND = 2'b01;
   localparam logic [1:0] DONE  = 2'b10;

   localparam logic [3:0] STEP     = 4'(ROUNDS_PER_CYCLE);
   localparam logic [3:0] LAST_CNT = 4'(16 - ROUNDS_PER_CYCLE);

   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
                                 10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5,   3,28,15,6,21,10,
                                 23,19,12,4,26,8,   16,7,27,20,13,2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48,
                                 44,49,39,56,34,53, 46,42,50,36,29,32};
   localparam int E_T [48] = '{32,1,2,3,4,5,     4,5,6,7,8,9,
                               8,9,10,11,12,13,  12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25,
                               24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

   // Each S-box is 64 nibbles, entry row*16+col stored from the MSB down.
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   // Table entries use DES numbering: bit 1 is the MSB of the input word.
   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      for (int i = 0; i < 64; i++) perm_ip[63 - i] = x[64 - IP_T[i]];
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      for (int i = 0; i < 64; i++) perm_fp[63 - i] = x[64 - FP_T[i]];
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      for (int i = 0; i < 56; i++) perm_pc1[55 - i] = x[64 - PC1_T[i]];
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      for (int i = 0; i < 48; i++) perm_pc2[47 - i] = x[56 - PC2_T[i]];
   endfunction

   function automatic logic [47:0] perm_e(input logic [31:0] x);
      for (int i = 0; i < 48; i++) perm_e[47 - i] = x[32 - E_T[i]];
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] x);
      for (int i = 0; i < 32; i++) perm_p[31 - i] = x[32 - P_T[i]];
   endfunction

   function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [5:0]  b;
      logic [5:0]  idx;
      logic [31:0] s;
      x = perm_e(r) ^ k;
      s = '0;
      for (int j = 0; j < 8; j++) begin
         b   = x[47 - 6*j -: 6];
         idx = {b[5], b[0], b[4:1]};
         s[31 - 4*j -: 4] = SBOX[j][255 - 4*int'(idx) -: 4];
      end
      return perm_p(s);
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
      case (n)
         2'd0:    return x;
         2'd1:    return {x[0], x[27:1]};
         default: return {x[1:0], x[27:2]};
      endcase
   endfunction

   // Right-rotation before decryption round k+1 undoes the encryption left-shift schedule.
   function automatic logic [1:0] shift_amt(input logic [3:0] k);
      if (k == 4'd0) return 2'd0;
      if (k == 4'd1 || k == 4'd8 || k == 4'd15) return 2'd1;
      return 2'd2;
   endfunction

   logic [1:0]  state_q;
   logic [3:0]  cnt_q;
   logic [31:0] l_q, r_q;
   logic [27:0] c_q, d_q;

   logic [31:0] l_n, r_n, tmp;
   logic [27:0] c_n, d_n;
   logic [3:0]  k;
   logic [63:0] ip_w;
   logic [55:0] pc1_w;

   assign ip_w  = perm_ip(data_in);
   assign pc1_w = perm_pc1(key_in);
   assign busy  = (state_q == ROUND);
   assign done  = (state_q == DONE);

   always_comb begin
      l_n = l_q;
      r_n = r_q;
      c_n = c_q;
      d_n = d_q;
      tmp = '0;
      k   = '0;
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
         k   = cnt_q + 4'(j);
         c_n = rotr(c_n, shift_amt(k));
         d_n = rotr(d_n, shift_amt(k));
         tmp = r_n;
         r_n = l_n ^ f_func(r_n, perm_pc2({c_n, d_n}));
         l_n = tmp;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         l_q      <= '0;
         r_q      <= '0;
         c_q      <= '0;
         d_q      <= '0;
         data_out <= '0;
      end else if (state_q == ROUND) begin
         l_q   <= l_n;
         r_q   <= r_n;
         c_q   <= c_n;
         d_q   <= d_n;
         cnt_q <= cnt_q + STEP;
         if (cnt_q == LAST_CNT) begin
            data_out <= perm_fp({r_n, l_n});
            cnt_q    <= '0;
            state_q  <= DONE;
         end
      end else if (load) begin
         {l_q, r_q} <= ip_w;
         {c_q, d_q} <= pc1_w;
         cnt_q      <= '0;
         state_q    <= ROUND;
      end else begin
         state_q <= IDLE;
      end
   end

endmodule
